dense_int_stream: RTL
=====================

// Module: dense_int_stream
// PURPOSE
// Int8 fully-connected layer for the classifier tail. Accepts H input rows (W*D int8 each) and accumulates B signed sums against ROM kernels.
// Processes P output neurons per cycle. Adds ROM bias, requantises (arith shift, saturate, optional ReLU) and streams B int8 results.
// Full valid/ready handshake on both sides; sits after the last conv/pool stage.
// PARAMETERS
// BIASFILE    "dense0_bias.txt"    bias init file; word = P x 32b, depth B/P
// KERNELFILE  "dense0_kernel.txt"  kernel init file; word = P x W*D*DATA_WIDTH, depth H*B/P
// H           3    input rows per frame
// W           3    row width
// D           12   input depth
// B           64   output neurons; B % P == 0 required
// P           1    parallel output lanes
// DATA_WIDTH  8    signed element width
// ACC_WIDTH   32   accumulator width
// SHIFT       16   requantisation right shift
// RELU        0    1: clamp negative outputs to 0
// PORTS
// clk      in   1                clock
// rst      in   1                reset; synchronous, active-high
// valid_i  in   1                input row valid
// ready_o  out  1                block can accept a row
// data_i   in   W*D*DATA_WIDTH   row; element k=d*W+w at [k*DATA_WIDTH+:DATA_WIDTH]
// valid_o  out  1                data_o valid
// ready_i  in   1                downstream accepts data_o
// data_o   out  DATA_WIDTH       signed int8 result, neuron index ascending
// last_o   out  1                marks neuron B-1
// BEHAVIOUR
// Interface: one clock clk; reset rst is synchronous and active-high.
// Reset: FSM->S_IDLE; all B accumulators=0; ready_o=0 for the reset cycle, then 1; valid_o=0, last_o=0, data_o=0. Applies mid-frame: partial sums are discarded.
// FSM states:
//   S_IDLE: ready_o=1. valid_i&ready_o captures data_i into row reg -> S_MAC.
//   S_MAC: ready_o=0. Group g=0..B/P-1 runs pipelined, one group/cycle. Kernel addr = g*H+h.
//     ROM latency is 1, so the stage lasts B/P+1 cycles.
//     Lane p (bits [p*W*D*DATA_WIDTH+:...]) updates acc[g*P+p] += sum over k of row[k]*kern[k].
//     Exit: if h<H-1 then h++ -> S_IDLE; else h=0 -> S_BFETCH.
//   S_BFETCH: 1 cycle; bias addr = b/P, lane b%P -> S_OUT.
//   S_OUT: data_o/valid_o registered and held stable until ready_i.
//     Each handshake clears acc[b] to 0.
//     If b==B-1: b=0 and -> S_IDLE; else b++ -> S_BFETCH.
//     Max output rate is 1 per 2 cycles.
// Arithmetic:
//   Products are signed DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH, sign-extended to ACC_WIDTH.
//   Accumulation wraps at ACC_WIDTH (two's complement, no internal saturation).
//   r = (acc[b] + bias[b]) >>> SHIFT.
//   data_o = sat(r) to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; if RELU and r<0 then 0.
// last_o=1 only with valid_o for b==B-1.
// valid_i while ready_o=0 is ignored; no row is lost or duplicated, so the upstream must hold.
// ready_i may toggle arbitrarily; data_o/last_o must not change while valid_o&~ready_i.
// Frame latency: H*(B/P+2) cycles of compute, excluding wait time, before the first valid_o.
// TESTING (cfg H=2 W=1 D=2 B=4 P=1 SHIFT=0 unless stated)
// 1 Kernels all 1, bias 0, rows {1,2},{3,4}, ready_i=1 -> data_o 10,10,10,10; last_o on 4th output only.
// 2 Kernels 127, bias 0, rows all 127 -> all outputs 127 (saturated).
//   Rows all -128 -> all outputs -128; same with RELU=1 -> all outputs 0.
// 3 Test 1 with ready_i=0 for 5 cycles after 2nd valid_o -> data_o=10 held stable; 4 outputs total, none dropped.
// 4 rst pulsed in S_MAC of row 0, then test 1 frame replayed -> outputs 10 (no stale partials); valid_o=0 during reset.
// 5 valid_i held high with changing data during S_OUT -> ignored; two back-to-back frames each give independent results (acc cleared).
// 6 B=8, P=2 vs P=1 (same neuron weights, random int8 data, SHIFT=4, bias +/-1000) -> bit-identical output sequences.

Source files
------------

// File: rtl/dense_int_stream_if.sv
// dense_int_stream_if
// Row-in / neuron-out stream bundle for the int8 dense layer.
//   valid_i, data_i : upstream row offer (data_i is one full W*D row)
//   ready_o         : layer can take a row this cycle
//   valid_o, data_o : one requantised int8 neuron result
//   last_o          : qualifies the final neuron of a frame
//   ready_i         : downstream accepts data_o
// The layer connects through the slave modport, its driver through master.
interface dense_int_stream_if #(
    parameter int ROW_WIDTH  = 288,
    parameter int DATA_WIDTH = 8
);
    logic                  valid_i;
    logic                  ready_o;
    logic [ROW_WIDTH-1:0]  data_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  last_o;

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, last_o
    );

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/dense_int_stream.sv
// dense_int_stream
// Int8 fully-connected layer. Accumulates H input rows per frame against
// ROM kernels into B signed accumulators, P output neurons per cycle, then
// adds a ROM bias, requantises (arithmetic shift, saturate, optional ReLU)
// and streams B int8 results in ascending neuron order.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : dense_int_stream_if.slave (row input, result output, handshakes)
// ROM contents:
//   KERNEL_INIT : H*B/P words of P*W*D*DATA_WIDTH bits, word a at
//                 [a*P*ROW_W +: P*ROW_W]; address = group*H + row,
//                 lane p at [p*ROW_W +: ROW_W], element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   BIAS_INIT   : B/P words of P*ACC_WIDTH bits; since words are stored
//                 lane-ascending, neuron n's bias sits at [n*ACC_WIDTH +: ACC_WIDTH]
// B must be a multiple of P.
//
// state    | meaning
// S_IDLE   | waiting for a row, ready_o high
// S_MAC    | one kernel group per cycle, B/P+1 cycles (1-cycle ROM latency)
// S_BFETCH | bias lookup and requantisation of neuron b into the output reg
// S_OUT    | result held on data_o until the downstream takes it
module dense_int_stream #(
    parameter int H          = 3,
    parameter int W          = 3,
    parameter int D          = 12,
    parameter int B          = 64,
    parameter int P          = 1,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT      = 16,
    parameter int RELU       = 0,
    parameter logic [H*B*W*D*DATA_WIDTH-1:0] KERNEL_INIT = '0,
    parameter logic [B*ACC_WIDTH-1:0]        BIAS_INIT   = '0
) (
    input logic               clk,
    input logic               rst,
    dense_int_stream_if.slave bus
);

    localparam int ELEMS  = W * D;
    localparam int ROW_W  = ELEMS * DATA_WIDTH;
    localparam int G      = B / P;
    localparam int KDEPTH = H * G;
    localparam int KAW    = (KDEPTH > 1) ? $clog2(KDEPTH) : 1;
    localparam int CW     = $clog2(G + 1);
    localparam int HW     = (H > 1) ? $clog2(H) : 1;
    localparam int BW     = (B > 1) ? $clog2(B) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MAC    = 2'd1;
    localparam logic [1:0] S_BFETCH = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    localparam logic [CW-1:0]  CNT_LAST = CW'(G);
    localparam logic [HW-1:0]  H_LAST   = HW'(H - 1);
    localparam logic [BW-1:0]  B_LAST   = BW'(B - 1);
    localparam logic [KAW-1:0] K_STEP   = KAW'(H);
    localparam logic [BW-1:0]  P_STEP   = BW'(P);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  ready_q;
    logic                  valid_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic [ROW_W-1:0]      row_q;
    logic [P*ROW_W-1:0]    kern_q;
    logic [CW-1:0]         cnt;
    logic [KAW-1:0]        kaddr;
    logic                  mac_valid;
    logic [BW-1:0]         mac_base;
    logic [HW-1:0]         h;
    logic [BW-1:0]         b;

    logic signed [ACC_WIDTH-1:0] acc [B];
    logic signed [ACC_WIDTH-1:0] lane_sum [P];

    logic [P*ROW_W-1:0]    kern_rom [KDEPTH];
    logic [ACC_WIDTH-1:0]  bias_rom [B];

    logic                  in_fire;
    logic                  out_fire;

    for (genvar i = 0; i < KDEPTH; i++) begin : g_kern_rom
        assign kern_rom[i] = KERNEL_INIT[i*P*ROW_W +: P*ROW_W];
    end

    for (genvar i = 0; i < B; i++) begin : g_bias_rom
        assign bias_rom[i] = BIAS_INIT[i*ACC_WIDTH +: ACC_WIDTH];
    end

    assign in_fire  = (state == S_IDLE) && bus.valid_i && ready_q;
    assign out_fire = (state == S_OUT) && valid_q && bus.ready_i;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (in_fire) state_next = S_MAC;
            end
            S_MAC: begin
                if (cnt == CNT_LAST) state_next = (h == H_LAST) ? S_BFETCH : S_IDLE;
            end
            S_BFETCH: begin
                state_next = S_OUT;
            end
            S_OUT: begin
                if (out_fire) state_next = (b == B_LAST) ? S_IDLE : S_BFETCH;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Dot product of the captured row against each lane of the registered
    // kernel word; products are sign-extended and the sum wraps at ACC_WIDTH.
    logic signed [2*DATA_WIDTH-1:0] prod;

    always_comb begin
        prod = '0;
        for (int p = 0; p < P; p++) begin
            lane_sum[p] = '0;
            for (int k = 0; k < ELEMS; k++) begin
                prod = $signed(row_q[k*DATA_WIDTH +: DATA_WIDTH])
                     * $signed(kern_q[p*ROW_W + k*DATA_WIDTH +: DATA_WIDTH]);
                lane_sum[p] = lane_sum[p]
                            + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
            end
        end
    end

    // Requantisation of neuron b: the shifted value fits in DATA_WIDTH only
    // when every bit from the int8 sign bit upward agrees.
    logic signed [ACC_WIDTH-1:0]   sum_b;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic [ACC_WIDTH-DATA_WIDTH:0] upper;
    logic [DATA_WIDTH-1:0]         q_val;

    always_comb begin
        sum_b   = acc[b] + $signed(bias_rom[b]);
        shifted = sum_b >>> SHIFT;
        upper   = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
        q_val   = shifted[DATA_WIDTH-1:0];
        if (!((&upper) || (~|upper))) begin
            q_val = shifted[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        if ((RELU != 0) && shifted[ACC_WIDTH-1]) q_val = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            row_q     <= '0;
            kern_q    <= '0;
            cnt       <= '0;
            kaddr     <= '0;
            mac_valid <= 1'b0;
            mac_base  <= '0;
            h         <= '0;
            b         <= '0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == S_IDLE);

            if (in_fire) begin
                row_q    <= bus.data_i;
                cnt      <= '0;
                kaddr    <= KAW'(h);
                mac_base <= '0;
            end

            // Issue side runs one cycle ahead of the accumulate side because
            // of the ROM register; the extra cycle at cnt==G drains it.
            if (state == S_MAC) begin
                if (cnt != CNT_LAST) begin
                    kern_q    <= kern_rom[kaddr];
                    kaddr     <= kaddr + K_STEP;
                    cnt       <= cnt + CW'(1);
                    mac_valid <= 1'b1;
                end else begin
                    mac_valid <= 1'b0;
                    h         <= (h == H_LAST) ? '0 : h + HW'(1);
                end
            end

            if (mac_valid) mac_base <= mac_base + P_STEP;

            if (state == S_BFETCH) begin
                data_q  <= q_val;
                valid_q <= 1'b1;
                last_q  <= (b == B_LAST);
            end

            if (out_fire) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                b       <= (b == B_LAST) ? '0 : b + BW'(1);
            end
        end
    end

    // Accumulators are cleared one at a time as each result leaves, so the
    // next frame starts from zero without a separate clear pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < B; i++) acc[i] <= '0;
        end else if (mac_valid) begin
            for (int p = 0; p < P; p++) begin
                acc[mac_base + BW'(p)] <= acc[mac_base + BW'(p)] + lane_sum[p];
            end
        end else if (out_fire) begin
            acc[b] <= '0;
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.last_o  = last_q;

endmodule
